// File: rtl/vlt_pkg.sv
// Shared types and helpers for the vulnerability accumulator.
// Holds the FSM state enum, default widths and the saturating adder.
package vlt_pkg;

    localparam int VLT_DUR_W   = 10;
    localparam int VLT_SHIFT_W = 4;
    localparam int VLT_TERM_W  = VLT_DUR_W + 2**VLT_SHIFT_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } vlt_acc_state_e;

    // Adds a and b and clamps at 2**w-1 (w <= 64).
    // Bit 64 of the result flags that clamping happened; bits 63:0 are the sum.
    function automatic logic [64:0] vlt_sat_add(input logic [63:0] a,
                                                input logic [63:0] b,
                                                input int unsigned w);
        logic [64:0] sum;
        logic [63:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        if (w >= 64) lim = '1;
        else         lim = (64'd1 << w) - 64'd1;
        if (sum > {1'b0, lim}) return {1'b1, lim};
        else                   return {1'b0, sum[63:0]};
    endfunction

endpackage

// File: rtl/vlt_term_calc.sv
// Combinational term generator:
//   term = (v1 ? dur << s1 : 0) + (v2 ? dur << s2 : 0)
// TERM_W is wide enough that neither the shifts nor the sum can overflow.
module vlt_term_calc
    import vlt_pkg::*;
#(
    parameter int DUR_W   = VLT_DUR_W,
    parameter int SHIFT_W = VLT_SHIFT_W,
    parameter int TERM_W  = DUR_W + 2**SHIFT_W
) (
    input  logic [SHIFT_W-1:0] shift1_i,
    input  logic               shift1_v_i,
    input  logic [SHIFT_W-1:0] shift2_i,
    input  logic               shift2_v_i,
    input  logic [DUR_W-1:0]   duration_i,
    output logic [TERM_W-1:0]  term_o
);

    logic [TERM_W-1:0] dur_ext;
    logic [TERM_W-1:0] part1;
    logic [TERM_W-1:0] part2;

    // Shift the zero-extended duration by each valid shift and sum the two parts.
    always_comb begin
        dur_ext = TERM_W'(duration_i);
        part1   = shift1_v_i ? (dur_ext << shift1_i) : '0;
        part2   = shift2_v_i ? (dur_ext << shift2_i) : '0;
        term_o  = part1 + part2;
    end

endmodule

// File: rtl/vlt_accum.sv
// Windowed vulnerability accumulator: registers terms from vlt_term_calc,
// sums them with saturation over a programmable cycle window and hands out
// one report per window through a valid/ack handshake.
// Optional feature: define VLT_ACCUM_PEAK_EN to add peak_o, the largest
// report since reset or clear_i.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | not running, ready_o low, waits for enable_i
//   ST_RUN    | accepting records, counting window cycles
//   ST_DRAIN  | one dead cycle so the last stage-1 term reaches acc
//   ST_REPORT | acc copied to report_o, acc and window count restart
module vlt_accum
    import vlt_pkg::*;
#(
    parameter int DUR_W   = VLT_DUR_W,
    parameter int SHIFT_W = VLT_SHIFT_W,
    parameter int ACC_W   = 48,
    parameter int WIN_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
    input  logic [WIN_W-1:0]   window_i,
    input  logic               clear_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [SHIFT_W-1:0] shift1_i,
    input  logic               shift1_v_i,
    input  logic [SHIFT_W-1:0] shift2_i,
    input  logic               shift2_v_i,
    input  logic [DUR_W-1:0]   duration_i,
    output logic               report_v_o,
    input  logic               report_ack_i,
    output logic [ACC_W-1:0]   report_o,
    output logic               lost_o,
    output logic               sat_o
`ifdef VLT_ACCUM_PEAK_EN
    ,
    output logic [ACC_W-1:0]   peak_o
`endif
);

    localparam int TERM_W = DUR_W + 2**SHIFT_W;

    vlt_acc_state_e    state_q, state_d;
    logic [WIN_W-1:0]  wcnt_q, wcnt_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WIN_W-1:0]  win_lim;
    logic [TERM_W-1:0] term_c, term_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  report_q;
    logic              report_v_q;
    logic              lost_q;
    logic              sat_q;
    logic [64:0]       sum;
    logic              sum_unused;
    logic              accept;

    vlt_term_calc #(
        .DUR_W   (DUR_W),
        .SHIFT_W (SHIFT_W),
        .TERM_W  (TERM_W)
    ) u_term_calc (
        .shift1_i   (shift1_i),
        .shift1_v_i (shift1_v_i),
        .shift2_i   (shift2_i),
        .shift2_v_i (shift2_v_i),
        .duration_i (duration_i),
        .term_o     (term_c)
    );

    // A window length of zero behaves as a one-cycle window.
    assign win_lim    = (win_q == '0) ? WIN_W'(1) : win_q;
    assign accept     = valid_i & ready_o;
    assign sum        = vlt_sat_add(64'(acc_q), 64'(term_q), ACC_W);
    assign sum_unused = ^sum;

    // Next-state logic; clear_i overrides everything and blocks acceptance.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        win_d   = win_q;
        ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                    win_d   = window_i;
                end
            end
            ST_RUN: begin
                ready_o = 1'b1;
                wcnt_d  = wcnt_q + WIN_W'(1);
                if ((wcnt_q == win_lim - WIN_W'(1)) || !enable_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                wcnt_d = '0;
                if (enable_i) begin
                    state_d = ST_RUN;
                    win_d   = window_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
            ready_o = 1'b0;
        end
    end

    // FSM state, window counter and the window length latched on RUN entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            win_q   <= win_d;
        end
    end

    // Two-stage datapath: register the term on accept, add it into acc next cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            term_q <= '0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
        end else if (clear_i) begin
            term_q <= '0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            term_q <= accept ? term_c : '0;
            if (state_q == ST_REPORT) begin
                acc_q <= '0;
            end else begin
                acc_q <= sum[ACC_W-1:0];
                if (sum[64]) sat_q <= 1'b1;
            end
        end
    end

    // Report register and handshake; a new report always wins over a pending ack.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            report_q   <= '0;
            report_v_q <= 1'b0;
            lost_q     <= 1'b0;
        end else if (clear_i) begin
            report_q   <= '0;
            report_v_q <= 1'b0;
            lost_q     <= 1'b0;
        end else if (state_q == ST_REPORT) begin
            report_q   <= acc_q;
            report_v_q <= 1'b1;
            if (report_v_q && !report_ack_i) lost_q <= 1'b1;
        end else if (report_ack_i) begin
            report_v_q <= 1'b0;
        end
    end

`ifdef VLT_ACCUM_PEAK_EN
    logic [ACC_W-1:0] peak_q;

    // Track the largest report, updated together with report_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            peak_q <= '0;
        end else if (clear_i) begin
            peak_q <= '0;
        end else if ((state_q == ST_REPORT) && (acc_q > peak_q)) begin
            peak_q <= acc_q;
        end
    end

    assign peak_o = peak_q;
`endif

    assign report_o   = report_q;
    assign report_v_o = report_v_q;
    assign lost_o     = lost_q;
    assign sat_o      = sat_q;

endmodule
